// File: rtl/mem_access_ctrl_if.sv
// Bundles the fetch port, data port and memory-side signals of mem_access_ctrl.
// The controller uses the slave modport; requesters and memory use master.
interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [DATA_WIDTH-1:0] if_addr;
  logic                  if_done;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [DATA_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_done;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  mar_enable;
  logic [DATA_WIDTH-1:0] mar_data;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_done, if_rdata, d_done, d_rdata,
    input  mar_enable, mar_data, mem_read, mem_write, mem_wdata, busy
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_done, if_rdata, d_done, d_rdata,
    output mar_enable, mar_data, mem_read, mem_write, mem_wdata, busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Arbitrates a fetch port and a data port onto one memory through a MAR,
// holding the read/write strobe for WAIT_CYCLES cycles; every output is registered.
module mem_access_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic              clock,
  input logic              clear,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_MAR,
    ACCESS,
    DONE
  } stateType;

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES - 1);

  stateType              r_state;
  logic [3:0]            r_waitCount;
  logic                  r_lastGrantData;
  logic                  r_grantFetch;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  r_ifDone;
  logic [DATA_WIDTH-1:0] r_ifRdata;
  logic                  r_dDone;
  logic [DATA_WIDTH-1:0] r_dRdata;
  logic                  r_marEnable;
  logic [DATA_WIDTH-1:0] r_marData;
  logic                  r_memRead;
  logic                  r_memWrite;
  logic [DATA_WIDTH-1:0] r_memWdata;
  logic                  r_busy;

  logic                  w_anyReq;
  logic                  w_grantFetch;

  // Round-robin: on a tie the port that was not served last wins.
  assign w_anyReq     = bus.if_req | bus.d_req;
  assign w_grantFetch = bus.if_req & (~bus.d_req | r_lastGrantData);

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state         <= IDLE;
      r_waitCount     <= '0;
      r_lastGrantData <= 1'b1;
      r_grantFetch    <= 1'b0;
      r_we            <= 1'b0;
      r_wdata         <= '0;
      r_ifDone        <= 1'b0;
      r_ifRdata       <= '0;
      r_dDone         <= 1'b0;
      r_dRdata        <= '0;
      r_marEnable     <= 1'b0;
      r_marData       <= '0;
      r_memRead       <= 1'b0;
      r_memWrite      <= 1'b0;
      r_memWdata      <= '0;
      r_busy          <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            // Everything the access needs is captured here so later requester changes are ignored.
            r_state         <= LOAD_MAR;
            r_grantFetch    <= w_grantFetch;
            r_lastGrantData <= ~w_grantFetch;
            r_we            <= ~w_grantFetch & bus.d_we;
            r_wdata         <= bus.d_wdata;
            r_marData       <= w_grantFetch ? bus.if_addr : bus.d_addr;
            r_marEnable     <= 1'b1;
            r_busy          <= 1'b1;
          end
        end

        LOAD_MAR: begin
          r_state     <= ACCESS;
          r_marEnable <= 1'b0;
          r_waitCount <= WaitLoad;
          r_memRead   <= ~r_we;
          r_memWrite  <= r_we;
          r_memWdata  <= r_we ? r_wdata : '0;
        end

        ACCESS: begin
          if (r_waitCount == 4'd0) begin
            // Memory read data is valid in this final strobe cycle.
            r_state    <= DONE;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_memWdata <= '0;
            r_ifDone   <= r_grantFetch;
            r_dDone    <= ~r_grantFetch;
            if (!r_we) begin
              if (r_grantFetch) begin
                r_ifRdata <= bus.mem_rdata;
              end else begin
                r_dRdata <= bus.mem_rdata;
              end
            end
          end else begin
            r_waitCount <= r_waitCount - 4'd1;
          end
        end

        DONE: begin
          r_state  <= IDLE;
          r_ifDone <= 1'b0;
          r_dDone  <= 1'b0;
          r_busy   <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.if_done    = r_ifDone;
  assign bus.if_rdata   = r_ifRdata;
  assign bus.d_done     = r_dDone;
  assign bus.d_rdata    = r_dRdata;
  assign bus.mar_enable = r_marEnable;
  assign bus.mar_data   = r_marData;
  assign bus.mem_read   = r_memRead;
  assign bus.mem_write  = r_memWrite;
  assign bus.mem_wdata  = r_memWdata;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// transactions compared against a transaction-level model of arbitration and memory.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  localparam int DW   = 32;
  localparam int WAIT = 2;

  logic clock = 1'b0;
  logic clear;

  always #5 clock = ~clock;

  mem_access_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  mem_access_ctrl #(
    .DATA_WIDTH (DW),
    .WAIT_CYCLES(WAIT)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  // Memory behind the MAR: the address is taken when the MAR load strobe is seen.
  logic [DW-1:0] mem [256];
  logic [7:0]    marLatched;

  always @(posedge clock) begin
    if (bus.mar_enable) marLatched <= bus.mar_data[7:0];
    if (bus.mem_write) mem[marLatched] <= bus.mem_wdata;
  end

  assign bus.mem_rdata = mem[marLatched];

  // Reference model: memory contents, last word returned on each port, last-served port.
  logic [DW-1:0] refMem [256];
  logic [DW-1:0] refIfRdata;
  logic [DW-1:0] refDRdata;
  bit            refLastData;

  int testCount = 0;
  int failCount = 0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic modelReset();
    refIfRdata  = '0;
    refDRdata   = '0;
    refLastData = 1'b1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".strobes"},
                32'({bus.busy, bus.mar_enable, bus.mem_read, bus.mem_write, bus.if_done, bus.d_done}),
                32'd0);
  endtask

  // Follows one service from the grant edge to its done pulse and checks it against the model.
  task automatic applyStimulus(input string tag, input bit expFetch, input bit expWe,
                               input logic [DW-1:0] expAddr, input logic [DW-1:0] expWdata,
                               input logic [DW-1:0] newAddr, input int expMarCycle, input bit dropReq);
    int            cycles    = 0;
    int            reads     = 0;
    int            writes    = 0;
    int            marLoads  = 0;
    int            marCycle  = -1;
    int            doneCycle = -1;
    int            strobeErr = 0;
    bit            sawDone   = 0;
    bit            gotFetch  = 0;
    bit            gotData   = 0;
    logic [DW-1:0] marSeen   = '0;
    logic [DW-1:0] expRead;
    expRead = refMem[expAddr[7:0]];
    while (!sawDone && cycles < 40) begin
      tick();
      cycles++;
      if (bus.mar_enable) begin
        marLoads++;
        marSeen  = bus.mar_data;
        marCycle = cycles;
        if (expFetch) begin
          bus.if_addr = newAddr;
        end else begin
          bus.d_addr  = newAddr;
          bus.d_wdata = ~expWdata;
        end
      end
      if (bus.mem_read && bus.mem_write) strobeErr++;
      if (bus.mem_read) reads++;
      if (bus.mem_write) begin
        writes++;
        if (bus.mem_wdata !== expWdata) strobeErr++;
      end else if (bus.mem_wdata !== '0) begin
        strobeErr++;
      end
      if ((bus.mem_read || bus.mem_write) && bus.mar_data !== expAddr) strobeErr++;
      if (bus.if_done || bus.d_done) begin
        sawDone   = 1;
        gotFetch  = bus.if_done;
        gotData   = bus.d_done;
        doneCycle = cycles;
      end
    end
    checkOutput({tag, ".doneSeen"}, 32'(sawDone), 32'd1);
    checkOutput({tag, ".port"}, 32'({gotFetch, gotData}), 32'({expFetch, ~expFetch}));
    checkOutput({tag, ".marCycle"}, 32'(marCycle), 32'(expMarCycle));
    checkOutput({tag, ".latency"}, 32'(doneCycle - marCycle), 32'(WAIT + 1));
    checkOutput({tag, ".marLoads"}, 32'(marLoads), 32'd1);
    checkOutput({tag, ".marData"}, marSeen, expAddr);
    checkOutput({tag, ".reads"}, 32'(reads), expWe ? 32'd0 : 32'(WAIT));
    checkOutput({tag, ".writes"}, 32'(writes), expWe ? 32'(WAIT) : 32'd0);
    checkOutput({tag, ".strobeErr"}, 32'(strobeErr), 32'd0);
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'd1);
    if (expWe) refMem[expAddr[7:0]] = expWdata;
    else if (expFetch) refIfRdata = expRead;
    else refDRdata = expRead;
    refLastData = ~expFetch;
    checkOutput({tag, ".ifRdata"}, bus.if_rdata, refIfRdata);
    checkOutput({tag, ".dRdata"}, bus.d_rdata, refDRdata);
    if (dropReq) begin
      if (expFetch) bus.if_req = 1'b0;
      else bus.d_req = 1'b0;
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] fa;
    logic [DW-1:0] da;
    logic [DW-1:0] dw;
    bit [1:0]      pat;
    bit            we;
    bit            fetchFirst;

    clear       = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      v = (i == 8'h15) ? 32'hDEADBEEF : $urandom;
      mem[i]    <= v;
      refMem[i]  = v;
    end
    modelReset();

    repeat (2) tick();
    checkIdle("reset");
    checkOutput("reset.marData", bus.mar_data, '0);
    checkOutput("reset.memWdata", bus.mem_wdata, '0);
    checkOutput("reset.ifRdata", bus.if_rdata, '0);
    checkOutput("reset.dRdata", bus.d_rdata, '0);
    clear = 1'b0;
    tick();
    checkIdle("idleNoReq");

    // Fetch read; the address is changed to 0x99 once granted and must not disturb the access.
    bus.if_addr = 32'h15;
    bus.if_req  = 1'b1;
    applyStimulus("fetch", 1'b1, 1'b0, 32'h15, '0, 32'h99, 1, 1'b1);
    checkOutput("fetch.word", bus.if_rdata, 32'hDEADBEEF);
    tick();
    checkIdle("fetch.after");

    // Data write, then read it back through the data port.
    bus.d_addr  = 32'h20;
    bus.d_wdata = 32'h12345678;
    bus.d_we    = 1'b1;
    bus.d_req   = 1'b1;
    applyStimulus("write", 1'b0, 1'b1, 32'h20, 32'h12345678, 32'h44, 1, 1'b1);
    tick();
    checkIdle("write.after");
    checkOutput("write.memory", mem[8'h20], 32'h12345678);
    bus.d_addr = 32'h20;
    bus.d_we   = 1'b0;
    bus.d_req  = 1'b1;
    applyStimulus("readBack", 1'b0, 1'b0, 32'h20, '0, 32'h20, 1, 1'b1);
    checkOutput("readBack.word", bus.d_rdata, 32'h12345678);
    tick();

    // Tie after reset: fetch, data, fetch, data with both requests held.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    modelReset();
    checkOutput("tie.resetIfRdata", bus.if_rdata, '0);
    bus.if_addr = 32'h41;
    bus.d_addr  = 32'h52;
    bus.d_we    = 1'b0;
    bus.if_req  = 1'b1;
    bus.d_req   = 1'b1;
    applyStimulus("tie1", 1'b1, 1'b0, 32'h41, '0, 32'h41, 1, 1'b0);
    applyStimulus("tie2", 1'b0, 1'b0, 32'h52, '0, 32'h52, 2, 1'b0);
    applyStimulus("tie3", 1'b1, 1'b0, 32'h41, '0, 32'h41, 2, 1'b1);
    applyStimulus("tie4", 1'b0, 1'b0, 32'h52, '0, 32'h52, 2, 1'b1);
    tick();
    checkIdle("tie.after");

    // Clear during the second access cycle aborts the fetch; the held request is served again.
    bus.if_addr = 32'h33;
    bus.if_req  = 1'b1;
    repeat (3) tick();
    checkOutput("abort.accessing", 32'(bus.mem_read), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    modelReset();
    checkIdle("abort");
    checkOutput("abort.marData", bus.mar_data, '0);
    checkOutput("abort.ifRdata", bus.if_rdata, '0);
    checkOutput("abort.dRdata", bus.d_rdata, '0);
    applyStimulus("reserve", 1'b1, 1'b0, 32'h33, '0, 32'h33, 1, 1'b1);
    tick();
    checkIdle("reserve.after");

    // Randomized request mixes against the model.
    for (int it = 0; it < 30; it++) begin
      pat = 2'($urandom_range(1, 3));
      fa  = $urandom;
      da  = $urandom;
      dw  = $urandom;
      we  = 1'($urandom_range(0, 1));
      bus.if_addr = fa;
      bus.d_addr  = da;
      bus.d_wdata = dw;
      bus.d_we    = we;
      bus.if_req  = pat[0];
      bus.d_req   = pat[1];
      fetchFirst  = (pat == 2'd1) ? 1'b1 : (pat == 2'd2) ? 1'b0 : refLastData;
      if (fetchFirst) applyStimulus("rnd.fetch", 1'b1, 1'b0, fa, '0, $urandom, 1, 1'b1);
      else applyStimulus("rnd.data", 1'b0, we, da, dw, $urandom, 1, 1'b1);
      if (pat == 2'd3) begin
        if (fetchFirst) applyStimulus("rnd.data2", 1'b0, we, da, dw, $urandom, 2, 1'b1);
        else applyStimulus("rnd.fetch2", 1'b1, 1'b0, fa, '0, $urandom, 2, 1'b1);
      end
      tick();
      checkIdle("rnd.after");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
